// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and coordinate type.
// Imported by the sync generator and the downstream region decoders.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bus: pixel-advance enable in, coordinates, blanking and sync out.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   pix_en;
  coord_t xx;
  coord_t yy;
  logic   aactive;
  logic   hsync;
  logic   vsync;
  logic   line_start;
  logic   frame_start;

  modport master (
    input  pix_en,
    output xx, yy, aactive, hsync, vsync, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  xx, yy, aactive, hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrap counter 0..MAX with enable; resets to MAX so the first enabled edge lands on 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W   = COORD_W,
  parameter int MAX = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         tc
);

  localparam logic [W-1:0] TOP = W'(MAX);

  always_comb begin
    tc  = (cnt == TOP);
    nxt = cnt;
    if (en) nxt = tc ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= TOP;
    else     cnt <= nxt;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: registered xx/yy, active flag, syncs and line/frame pulses.
// All decodes use the next counter values so every output describes the same pixel.
module vga_sync_gen #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input logic            Pclk,
  input logic            rst,
  vga_sync_gen_if.master bus
);

  localparam int CW      = vga_timing_pkg::COORD_W;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
    end
  endgenerate

  localparam logic [CW-1:0] HA       = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA       = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
  logic          h_tc, v_tc, v_en;
  logic          aactive_q, hsync_q, vsync_q, line_start_q, frame_start_q;

  assign v_en = bus.pix_en & h_tc;

  vga_axis_counter #(.W(CW), .MAX(H_TOTAL - 1)) u_h_cnt (
    .clk (Pclk),
    .rst (rst),
    .en  (bus.pix_en),
    .cnt (h_cnt),
    .nxt (h_nxt),
    .tc  (h_tc)
  );

  vga_axis_counter #(.W(CW), .MAX(V_TOTAL - 1)) u_v_cnt (
    .clk (Pclk),
    .rst (rst),
    .en  (v_en),
    .cnt (v_cnt),
    .nxt (v_nxt),
    .tc  (v_tc)
  );

  // Wrap of h (and v) on an enabled edge is exactly the edge that loads 0.
  always_ff @(posedge Pclk or posedge rst) begin
    if (rst) begin
      aactive_q     <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      aactive_q     <= (h_nxt < HA) && (v_nxt < VA);
      hsync_q       <= ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_start_q  <= bus.pix_en & h_tc;
      frame_start_q <= bus.pix_en & h_tc & v_tc;
    end
  end

  assign bus.xx          = h_cnt;
  assign bus.yy          = v_cnt;
  assign bus.aactive     = aactive_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing plus a tiny active-high-sync config,
// both checked every cycle against a linear-pixel-index raster model.
module tb_vga_sync_gen;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  vga_sync_gen_if bus0();
  vga_sync_gen_if bus1();

  vga_sync_gen dut0 (.Pclk(pclk), .rst(rst), .bus(bus0));

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut1 (.Pclk(pclk), .rst(rst), .bus(bus1));

  always #20 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  int HA[2]  = '{640, 8};
  int HF[2]  = '{16, 2};
  int HS[2]  = '{96, 2};
  int HB[2]  = '{48, 2};
  int VA[2]  = '{480, 4};
  int VF[2]  = '{10, 1};
  int VS[2]  = '{2, 1};
  int VB[2]  = '{33, 1};
  bit POL[2] = '{1'b0, 1'b1};

  int mx[2], my[2];
  bit mls[2], mfs[2];

  int f_cnt, f_ls, f_frames;
  bit f_prev;

  function automatic int ht(int d);
    return HA[d] + HF[d] + HS[d] + HB[d];
  endfunction

  function automatic int vt(int d);
    return VA[d] + VF[d] + VS[d] + VB[d];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mx[d] = ht(d) - 1;
      my[d] = vt(d) - 1;
      mls[d] = 1'b0;
      mfs[d] = 1'b0;
    end
    f_prev = 1'b0;
    f_cnt  = 0;
    f_ls   = 0;
  endtask

  task automatic model_step(input bit en);
    int lin;
    for (int d = 0; d < 2; d++) begin
      if (en) begin
        lin    = (my[d] * ht(d) + mx[d] + 1) % (ht(d) * vt(d));
        mx[d]  = lin % ht(d);
        my[d]  = lin / ht(d);
        mls[d] = (mx[d] == 0);
        mfs[d] = mls[d] && (my[d] == 0);
      end else begin
        mls[d] = 1'b0;
        mfs[d] = 1'b0;
      end
    end
  endtask

  task automatic compare_one(input int d, input int xx, input int yy, input bit aa,
                             input bit hs, input bit vs, input bit ls, input bit fs);
    bit e_aa, e_hs, e_vs;
    string p;
    p    = $sformatf("dut%0d", d);
    e_aa = (mx[d] < HA[d]) && (my[d] < VA[d]);
    e_hs = (mx[d] >= HA[d] + HF[d] && mx[d] < HA[d] + HF[d] + HS[d]) ? POL[d] : !POL[d];
    e_vs = (my[d] >= VA[d] + VF[d] && my[d] < VA[d] + VF[d] + VS[d]) ? POL[d] : !POL[d];
    chk({p, ".xx"}, xx, mx[d]);
    chk({p, ".yy"}, yy, my[d]);
    chk({p, ".aactive"}, int'(aa), int'(e_aa));
    chk({p, ".hsync"}, int'(hs), int'(e_hs));
    chk({p, ".vsync"}, int'(vs), int'(e_vs));
    chk({p, ".line_start"}, int'(ls), int'(mls[d]));
    chk({p, ".frame_start"}, int'(fs), int'(mfs[d]));
  endtask

  task automatic compare_all();
    compare_one(0, int'(bus0.xx), int'(bus0.yy), bus0.aactive, bus0.hsync, bus0.vsync,
                bus0.line_start, bus0.frame_start);
    compare_one(1, int'(bus1.xx), int'(bus1.yy), bus1.aactive, bus1.hsync, bus1.vsync,
                bus1.line_start, bus1.frame_start);
  endtask

  // One Pclk: drive enable, let the edge happen, then check at the falling edge.
  task automatic cycle(input bit en);
    bus0.pix_en = en;
    bus1.pix_en = en;
    @(posedge pclk);
    if (!rst) begin
      model_step(en);
      if (en) f_cnt++;
    end
    @(negedge pclk);
    compare_all();
    if (bus1.frame_start) begin
      if (f_prev) begin
        chk("small.frame_cycles", f_cnt, 98);
        chk("small.frame_lines", f_ls, 7);
        f_frames++;
      end
      f_prev = 1'b1;
      f_cnt  = 0;
      f_ls   = 0;
    end
    if (bus1.line_start) f_ls++;
  endtask

  task automatic run_until(input int x, input int y, input int budget);
    int n;
    n = 0;
    while (!(mx[0] == x && my[0] == y) && n < budget) begin
      cycle(1'b1);
      n++;
    end
    if (!(mx[0] == x && my[0] == y)) chk("run_until_budget", n, -1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cnt, hs_first, hs_last, vs_low, s_min, s_max;
    bus0.pix_en = 1'b0;
    bus1.pix_en = 1'b0;
    f_frames = 0;
    model_reset();
    repeat (2) @(negedge pclk);
    compare_all();
    chk("rst.xx", int'(bus0.xx), 799);
    chk("rst.yy", int'(bus0.yy), 524);
    chk("rst.hsync", int'(bus0.hsync), 1);
    chk("rst.vsync", int'(bus0.vsync), 1);
    chk("rst.small_hsync", int'(bus1.hsync), 0);

    rst = 1'b0;
    cycle(1'b1);
    chk("first.xx", int'(bus0.xx), 0);
    chk("first.yy", int'(bus0.yy), 0);
    chk("first.aactive", int'(bus0.aactive), 1);
    chk("first.line_start", int'(bus0.line_start), 1);
    chk("first.frame_start", int'(bus0.frame_start), 1);
    cycle(1'b1);
    chk("second.line_start", int'(bus0.line_start), 0);
    chk("second.frame_start", int'(bus0.frame_start), 0);

    run_until(100, 0, 200);
    cycle(1'b1); chk("en.1", int'(bus0.xx), 101);
    cycle(1'b0); chk("en.0a", int'(bus0.xx), 101);
    cycle(1'b0); chk("en.0b", int'(bus0.xx), 101);
    cycle(1'b1); chk("en.1b", int'(bus0.xx), 102);

    run_until(799, 5, 6000);
    cycle(1'b1);
    chk("wrap.xx", int'(bus0.xx), 0);
    chk("wrap.yy", int'(bus0.yy), 6);
    chk("wrap.line_start", int'(bus0.line_start), 1);
    chk("wrap.frame_start", int'(bus0.frame_start), 0);
    cycle(1'b0);
    chk("gated.line_start", int'(bus0.line_start), 0);
    chk("gated.xx", int'(bus0.xx), 0);

    run_until(799, 9, 4000);
    hs_cnt = 0; hs_first = -1; hs_last = -1; vs_low = 0;
    for (int i = 0; i < 800; i++) begin
      cycle(1'b1);
      if (!bus0.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(bus0.xx);
        hs_last = int'(bus0.xx);
      end
      if (!bus0.vsync) vs_low++;
    end
    chk("hsync.width", hs_cnt, 96);
    chk("hsync.first", hs_first, 656);
    chk("hsync.last", hs_last, 751);
    chk("hsync.vsync_low", vs_low, 0);

    run_until(300, 11, 2000);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("midrst.xx", int'(bus0.xx), 799);
    chk("midrst.yy", int'(bus0.yy), 524);
    chk("midrst.aactive", int'(bus0.aactive), 0);
    @(negedge pclk);
    compare_all();
    rst = 1'b0;
    cycle(1'b1);
    chk("rerel.xx", int'(bus0.xx), 0);
    chk("rerel.frame_start", int'(bus0.frame_start), 1);

    s_min = 1000; s_max = -1;
    repeat (6000) begin
      cycle($urandom_range(0, 3) != 0);
      if (bus1.hsync) begin
        if (int'(bus1.xx) < s_min) s_min = int'(bus1.xx);
        if (int'(bus1.xx) > s_max) s_max = int'(bus1.xx);
      end
    end
    chk("small.hsync_min", s_min, 10);
    chk("small.hsync_max", s_max, 11);
    chk("small.frames_seen", int'(f_frames >= 10), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
